// File: rtl/rr_arb4.sv
// Four-requester round-robin arbiter with hold and timeout.
// The grant rotates from the last holder; the holder may keep it until a timeout while others wait.
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | no requester owns the resource, grant = 0
// BUSY  | exactly one grant bit set, hold_cnt counting
module rr_arb4 #(
    parameter int MAX_HOLD = 4,
    parameter int CW       = $clog2(MAX_HOLD)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [1:0] grant_id,
    output logic       grant_valid,
    output logic       any_req
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state_q, state_d;
    logic [3:0]      grant_q, grant_d;
    logic [1:0]      grant_id_q, grant_id_d;
    logic            grant_valid_q, grant_valid_d;
    logic [CW-1:0]   hold_cnt_q, hold_cnt_d;
    logic [1:0]      last_q, last_d;

    logic [3:0]      holder_onehot;
    logic [3:0]      others;
    logic            holder_req;
    logic            timeout;
    logic [1:0]      pick_any;
    logic [1:0]      pick_other;

    // First set bit of mask in order from+1, from+2, ... wrapping mod 4.
    function automatic logic [1:0] next_in_order(input logic [3:0] mask, input logic [1:0] from);
        logic [1:0] idx;
        logic [1:0] sel;
        logic       found;
        sel   = from;
        found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idx = from + 2'(i);
            if (!found && mask[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    assign any_req       = |req;
    assign holder_onehot = 4'b0001 << grant_id_q;
    assign holder_req    = |(req & holder_onehot);
    assign others        = req & ~holder_onehot;
    assign timeout       = (hold_cnt_q == CW'(MAX_HOLD - 1));
    assign pick_any      = next_in_order(req, last_q);
    assign pick_other    = next_in_order(others, last_q);

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        grant_id_d    = grant_id_q;
        grant_valid_d = grant_valid_q;
        hold_cnt_d    = hold_cnt_q;
        last_d        = last_q;
        case (state_q)
            IDLE: begin
                hold_cnt_d = '0;
                if (any_req) begin
                    state_d       = BUSY;
                    grant_d       = 4'b0001 << pick_any;
                    grant_id_d    = pick_any;
                    grant_valid_d = 1'b1;
                    last_d        = pick_any;
                end
            end
            BUSY: begin
                // A drop and a timeout with waiters both hand over to the next requester.
                if (!holder_req || (timeout && |others)) begin
                    if (|others) begin
                        grant_d       = 4'b0001 << pick_other;
                        grant_id_d    = pick_other;
                        grant_valid_d = 1'b1;
                        last_d        = pick_other;
                        hold_cnt_d    = '0;
                    end else begin
                        state_d       = IDLE;
                        grant_d       = 4'b0000;
                        grant_valid_d = 1'b0;
                        hold_cnt_d    = '0;
                    end
                end else if (!timeout) begin
                    hold_cnt_d = hold_cnt_q + CW'(1);
                end
            end
            default: begin
                state_d       = IDLE;
                grant_d       = 4'b0000;
                grant_valid_d = 1'b0;
                hold_cnt_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            grant_q       <= 4'b0000;
            grant_id_q    <= 2'd0;
            grant_valid_q <= 1'b0;
            hold_cnt_q    <= '0;
            last_q        <= 2'd3;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            grant_id_q    <= grant_id_d;
            grant_valid_q <= grant_valid_d;
            hold_cnt_q    <= hold_cnt_d;
            last_q        <= last_d;
        end
    end

    assign grant       = grant_q;
    assign grant_id    = grant_id_q;
    assign grant_valid = grant_valid_q;

endmodule

// File: tb/tb_rr_arb4.sv
// Bench for rr_arb4: directed scenarios plus random traffic, checked by a scoreboard
// fed from a cycle-level ownership model of the arbiter.
module tb_rr_arb4;

    localparam int MAX_HOLD = 4;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] grant_id;
    logic       grant_valid;
    logic       any_req;

    rr_arb4 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .grant       (grant),
        .grant_id    (grant_id),
        .grant_valid (grant_valid),
        .any_req     (any_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] g;
        logic [1:0] id;
        logic       v;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   stim_done = 0;

    // Model: who owns the resource, how many cycles it has held it, and the rotation pointer.
    int m_owner = -1;
    int m_last  = 3;
    int m_held  = 0;
    int m_id    = 0;

    task automatic model_step(input logic r, input logic [3:0] q);
        logic [3:0] cand;
        int         pick;
        exp_t       e;
        if (r) begin
            m_owner = -1;
            m_last  = 3;
            m_held  = 0;
            m_id    = 0;
        end else begin
            cand = (m_owner >= 0) ? (q & ~(4'b0001 << m_owner)) : q;
            if (m_owner >= 0 && q[m_owner] && !(m_held >= MAX_HOLD && cand != 4'b0000)) begin
                if (m_held < MAX_HOLD) m_held++;
            end else begin
                pick = -1;
                for (int k = 1; k <= 4; k++)
                    if (pick < 0 && cand[(m_last + k) % 4]) pick = (m_last + k) % 4;
                if (pick >= 0) begin
                    m_owner = pick;
                    m_last  = pick;
                    m_id    = pick;
                    m_held  = 1;
                end else begin
                    m_owner = -1;
                    m_held  = 0;
                end
            end
        end
        e.g  = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
        e.id = 2'(m_id);
        e.v  = (m_owner >= 0);
        exp_q.push_back(e);
    endtask

    // Drive one cycle of inputs on the falling edge; any_req is checked right away.
    task automatic step(input logic r, input logic [3:0] q);
        @(negedge clk);
        rst = r;
        req = q;
        #1;
        checks++;
        if (any_req !== (q != 4'b0000)) begin
            errors++;
            $display("FAIL any_req req=%b got=%b want=%b", q, any_req, (q != 4'b0000));
        end
        model_step(r, q);
    endtask

    // Monitor: each active edge presents a new registered output set.
    initial begin
        exp_t e;
        while (!stim_done) begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (grant !== e.g) begin
                    errors++;
                    $display("FAIL grant t=%0t got=%b want=%b", $time, grant, e.g);
                end
                checks++;
                if (grant_valid !== e.v) begin
                    errors++;
                    $display("FAIL grant_valid t=%0t got=%b want=%b", $time, grant_valid, e.v);
                end
                checks++;
                if (grant_id !== e.id) begin
                    errors++;
                    $display("FAIL grant_id t=%0t got=%0d want=%0d", $time, grant_id, e.id);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req = 4'b0000;

        // Reset with all requesting, then first grant to a.
        repeat (3) step(1'b1, 4'b1111);
        step(1'b0, 4'b1111);

        // Full contention rotation with timeout.
        step(1'b1, 4'b0000);
        repeat (17) step(1'b0, 4'b1111);

        // Lone requester c holds indefinitely, then releases.
        step(1'b1, 4'b0000);
        repeat (10) step(1'b0, 4'b0100);
        repeat (2) step(1'b0, 4'b0000);

        // Holder b drops while a and d request: d wins with no idle bubble.
        step(1'b1, 4'b0000);
        repeat (2) step(1'b0, 4'b0010);
        repeat (3) step(1'b0, 4'b1001);

        // any_req across every request pattern under reset.
        for (int i = 0; i < 16; i++) step(1'b1, 4'(i));

        // Mid-grant reset of holder c, then c again and timeout hand-over to d.
        step(1'b1, 4'b0000);
        repeat (3) step(1'b0, 4'b0100);
        step(1'b1, 4'b1100);
        repeat (7) step(1'b0, 4'b1100);

        // Random traffic with occasional reset.
        step(1'b1, 4'b0000);
        for (int n = 0; n < 400; n++) begin
            logic [3:0] r4;
            r4 = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) r4 = req;
            step(($urandom_range(0, 49) == 0), r4);
        end

        step(1'b0, 4'b0000);
        repeat (2) @(posedge clk);
        #2;
        stim_done = 1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d want=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_arb4.md
# rr_arb4

Four-requester round-robin arbiter with hold and timeout, sharing a single downstream resource among requesters a, b, c, d (bits 0..3). It sits in front of the 4-input OR-reduction datapath. The combinational `any_req` output is the OR4 of the request lines. The registered one-hot `grant` selects which requester owns the resource. The block provides fair rotation, lets a holder keep the grant while it keeps requesting, and forces hand-over after `MAX_HOLD` cycles when others are waiting.

## Interface
- `MAX_HOLD`, default 4: maximum consecutive grant cycles for one holder while another request is pending. Legal range 2..255.
- `CW`, default `$clog2(MAX_HOLD)`: hold-counter width. Derived; never overridden.

Ports (name, direction, width, meaning):
- `clk`, input, 1: single clock, rising-edge.
- `rst`, input, 1: synchronous, active-high reset.
- `req`, input, 4: request lines; bit0=a, bit1=b, bit2=c, bit3=d; level-sensitive.
- `grant`, output, 4: registered; one-hot or all-zero.
- `grant_id`, output, 2: registered; index of the current holder. Value is held but meaningless when `grant_valid`=0.
- `grant_valid`, output, 1: registered; equals `|grant`.
- `any_req`, output, 1: combinational; `req[0]|req[1]|req[2]|req[3]`.

## Operation
- States:
  - IDLE: `grant`=0.
  - BUSY: exactly one `grant` bit set.
- Rotation pointer `last` (2 bits):
  - Search order starts at `last+1` and goes mod 4.
  - `last` updates to the new holder's index on every new grant.
- IDLE transitions:
  - If `req`≠0, grant the first set bit in search order and go to BUSY.
  - `hold_cnt` is set to 0.
- BUSY, holder's `req` bit is low:
  - If other requests are present, switch directly to the next requester in search order. No idle bubble.
  - Otherwise go to IDLE.
- BUSY, holder's `req` bit is high and `hold_cnt` == `MAX_HOLD`-1:
  - If any other `req` bit is set, force hand-over to the next requester after the holder. The holder is excluded from that search even though it is still requesting.
  - If no other request is set, the holder keeps the grant and `hold_cnt` saturates at `MAX_HOLD`-1.
- BUSY, holder's `req` bit is high and `hold_cnt` < `MAX_HOLD`-1: hold the grant and increment `hold_cnt`.
- Every new grant, including a direct switch or forced hand-over, resets `hold_cnt` to 0.
- A `req` bit may drop at any time without penalty; non-holders are not latched.
- Simultaneous holder drop and timeout: treat as a drop. The result is the same next-requester selection.
- `grant`, `grant_id`, `grant_valid`, `hold_cnt` and `last` come from a single registered update; no glitches.

## Timing
- Reset (`rst`=1 at an edge): after that edge `grant`=4'b0000, `grant_id`=2'd0, `grant_valid`=0, `hold_cnt`=0, `last`=3. With this reset value, `req[0]` has first priority after reset.
- Reset mid-operation: the grant is dropped at the same edge regardless of `req`. `rst` has priority over all transitions.
- Request-to-grant latency: `req` sampled high at edge n gives `grant` asserted after edge n, i.e. visible during cycle n+1. There is no combinational path from `req` to `grant`.
- Release latency: holder `req` sampled low at edge n gives the new `grant` value after edge n.
- Timeout: a holder with a competing request pending keeps the grant for exactly `MAX_HOLD` cycles, then the grant moves at the next edge.
- `any_req` follows `req` in the same cycle; it is unaffected by `rst`.

## Test plan
Scenarios 2–6 use `MAX_HOLD`=4.

1. Reset with `req`=4'b1111 held high → `grant`=0, `grant_valid`=0 while `rst`=1. At the first edge after `rst` falls, `grant`=4'b0001 and `grant_id`=0.
2. `req`=4'b1111 held for 16 cycles → grant sequence 0001×4, 0010×4, 0100×4, 1000×4, then 0001. `grant_valid` stays 1 throughout.
3. `req`=4'b0100 alone for 10 cycles → `grant`=4'b0100 for all 10 cycles; `hold_cnt` saturates at 3 with no hand-over. `req` → 0 gives `grant`=0 the next cycle.
4. Holder b (`req`=4'b0010 granted). Then `req`=4'b1001 with b dropped in the same cycle → `grant`=4'b1000 next cycle (search starts at c; d found first). No zero cycle in between.
5. `any_req` check over all 16 `req` values with `rst`=1 → `any_req`=0 only for 4'b0000 and 1 otherwise, evaluated in the same cycle.
6. Mid-grant reset: holder c with `hold_cnt`=2, assert `rst` for one cycle with `req`=4'b1100 → `grant`=0 after the reset edge, then `grant`=4'b0100 (c, the first of the requesters 2 and 3 in order from `last`=3 → index 0 onward). Then hand-over to d after 4 cycles.
